// File: rtl/math_pkg.sv
// Signed-range helpers shared by the saturating MAC and its clamp stages.
// Widths are assumed to be at most 63 bits so bounds fit in a longint.
package math_pkg;

    // Largest value a signed n-bit word can hold.
    function automatic longint smax(input int n);
        return (longint'(1) <<< (n - 1)) - 1;
    endfunction

    // Smallest value a signed n-bit word can hold.
    function automatic longint smin(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

    function automatic int clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >>> 1;
        end
        return r;
    endfunction

    // Half of one output LSB after a right shift by sh; zero when there is no shift.
    function automatic longint round_half(input int sh);
        return (sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0);
    endfunction

    // The accumulator must hold one full product without wrapping.
    function automatic bit acc_fits(input int accs, input int as, input int bs);
        return accs >= (as + bs);
    endfunction

endpackage

// File: rtl/saturating_mac_sat_narrow.sv
// Combinational signed clamp from INS bits down to OUTS bits; hit flags a value
// strictly outside the OUTS-bit range (the most negative value is legal).
module sat_narrow
    import math_pkg::*;
#(
    parameter int INS  = 25,
    parameter int OUTS = 24
) (
    input  logic [INS-1:0]  in,
    output logic [OUTS-1:0] out,
    output logic            hit
);

    generate
        if (INS > OUTS) begin : g_clamp
            localparam logic [OUTS-1:0] MAXV = OUTS'(smax(OUTS));
            localparam logic [OUTS-1:0] MINV = OUTS'(smin(OUTS));

            // In range exactly when every bit above the output sign bit matches it.
            logic [INS-OUTS:0] top;
            assign top = in[INS-1:OUTS-1];

            always_comb begin
                hit = !((&top) || !(|top));
                out = in[OUTS-1:0];
                if (hit) begin
                    out = in[INS-1] ? MINV : MAXV;
                end
            end
        end else begin : g_extend
            assign out = OUTS'($signed(in));
            assign hit = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/saturating_mac.sv
// Pipelined signed MAC over first/last framed bursts with saturating accumulate,
// scaled output and sticky per-frame saturation. Macro SATURATING_MAC_ROUND_EN adds round-half-up.
module saturating_mac
    import math_pkg::*;
#(
    parameter int AS     = 8,
    parameter int BS     = 8,
    parameter int ACCS   = 24,
    parameter int OFFSET = 0,
    parameter int OUTS   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AS-1:0]   in_a,
    input  logic [BS-1:0]   in_b,
    input  logic            in_first,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OUTS-1:0] out_data,
    output logic            out_sat
);

    localparam int PS = AS + BS;

    generate
        if (!acc_fits(ACCS, AS, BS)) begin : g_width_check
            $error("saturating_mac: ACCS must be >= AS+BS");
        end
    endgenerate

    // One stall signal freezes the whole pipe while a result waits for its consumer.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // vld_pipe[0]: beat in S1 (product registered); vld_pipe[1]: beat folded into acc.
    logic [1:0]             vld_pipe;
    logic signed [PS-1:0]   prod;
    logic signed [PS-1:0]   s1_prod;
    logic                   s1_first;
    logic                   s1_last;
    logic                   s2_last;
    logic signed [ACCS-1:0] acc;
    logic                   sticky;

    assign prod = PS'($signed(in_a)) * PS'($signed(in_b));

    // S2: one guard bit above the accumulator so the sum never wraps before clamping.
    logic signed [ACCS:0]   base;
    logic signed [ACCS:0]   sum;
    logic [ACCS-1:0]        s2_acc;
    logic                   s2_hit;

    assign base = s1_first ? '0 : (ACCS+1)'(acc);
    assign sum  = base + (ACCS+1)'(s1_prod);

    sat_narrow #(
        .INS  (ACCS + 1),
        .OUTS (ACCS)
    ) u_s2_sat (
        .in  (sum),
        .out (s2_acc),
        .hit (s2_hit)
    );

    // S3: scale the finished accumulator, optionally rounding, then clamp to the output.
    logic signed [ACCS:0]   acc_x;
    logic signed [ACCS:0]   rnd;
    logic signed [ACCS:0]   shifted;
    logic [OUTS-1:0]        s3_out;
    logic                   s3_hit;

    assign acc_x = (ACCS+1)'(acc);

`ifdef SATURATING_MAC_ROUND_EN
    localparam logic signed [ACCS:0] RND_K = (ACCS+1)'(round_half(OFFSET));
    assign rnd = acc_x + RND_K;
`else
    assign rnd = acc_x;
`endif

    assign shifted = rnd >>> OFFSET;

    sat_narrow #(
        .INS  (ACCS + 1),
        .OUTS (OUTS)
    ) u_s3_sat (
        .in  (shifted),
        .out (s3_out),
        .hit (s3_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_prod   <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[0], in_valid};
            s1_prod  <= prod;
            s1_first <= in_first;
            s1_last  <= in_last;
            s2_last  <= s1_last;
            if (vld_pipe[0]) begin
                acc    <= s2_acc;
                sticky <= (!s1_first && sticky) || s2_hit;
            end
            // S3 reads acc/sticky before this edge's S2 update, so a following
            // frame's first beat cannot disturb the result being emitted.
            out_valid <= vld_pipe[1] && s2_last;
            if (vld_pipe[1] && s2_last) begin
                out_data <= s3_out;
                out_sat  <= sticky || s3_hit;
            end
        end
    end

endmodule
